// File: rtl/mips_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer holding HI/LO.
// Uses an external 32-bit ALU, issuing one add or subtract per cycle.
module mips_muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out
);

  typedef enum logic [2:0] {
    IDLE, ABS_A, ABS_B, ITER, FIX_LO, FIX_HI, DONE
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] acc, wlo, opb;
  logic [5:0]  cnt;
  logic        neg_q, neg_r, lo_zero;

  logic        is_div, is_signed;
  logic [31:0] div_rs;
  logic        mul_carry, div_accept;
  logic [31:0] iter_acc, iter_wlo, fix_acc;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  assign div_rs     = {acc[30:0], wlo[31]};
  assign mul_carry  = (alu_out < acc);
  // acc[31] set means the shifted partial remainder is 33 bits wide, so it always covers opb.
  assign div_accept = acc[31] | (div_rs >= opb);

  always_comb begin
    alu_control = 3'd0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    unique case (state)
      ABS_A: begin alu_control = ALU_SUB; alu_b = wlo; end
      ABS_B: begin alu_control = ALU_SUB; alu_b = opb; end
      ITER: begin
        alu_control = is_div ? ALU_SUB : ALU_ADD;
        alu_a       = is_div ? div_rs : acc;
        alu_b       = opb;
      end
      FIX_LO: begin alu_control = ALU_SUB; alu_b = wlo; end
      FIX_HI: begin
        if (is_div) begin
          alu_control = ALU_SUB;
          alu_b       = acc;
        end else begin
          // Two's-complement of the 64-bit product: high word gets ~hi plus the low-word carry.
          alu_control = ALU_ADD;
          alu_a       = ~acc;
          alu_b       = {31'b0, lo_zero};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    iter_acc = acc;
    iter_wlo = wlo;
    if (is_div) begin
      iter_acc = div_accept ? alu_out : div_rs;
      iter_wlo = {wlo[30:0], div_accept};
    end else if (wlo[0]) begin
      {iter_acc, iter_wlo} = {mul_carry, alu_out, wlo[31:1]};
    end else begin
      {iter_acc, iter_wlo} = {1'b0, acc, wlo[31:1]};
    end
    fix_acc = (is_div ? neg_r : neg_q) ? alu_out : acc;
  end

  // hi/lo load on the edge entering DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= 2'd0;
      acc     <= 32'd0;
      wlo     <= 32'd0;
      opb     <= 32'd0;
      cnt     <= 6'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      lo_zero <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op_q    <= op;
          wlo     <= rs_data;
          opb     <= rt_data;
          acc     <= 32'd0;
          cnt     <= 6'd0;
          lo_zero <= 1'b0;
          neg_q   <= op[0] & (rs_data[31] ^ rt_data[31]);
          neg_r   <= (op == 2'b11) & rs_data[31];
          if (op[1] && rt_data == 32'd0) begin
            hi    <= rs_data;
            lo    <= 32'hFFFF_FFFF;
            state <= DONE;
          end else if (op[0]) begin
            state <= ABS_A;
          end else begin
            state <= ITER;
          end
        end
        ABS_A: begin
          if (wlo[31]) wlo <= alu_out;
          state <= ABS_B;
        end
        ABS_B: begin
          if (opb[31]) opb <= alu_out;
          state <= ITER;
        end
        ITER: begin
          acc <= iter_acc;
          wlo <= iter_wlo;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            if (is_signed) begin
              state <= FIX_LO;
            end else begin
              hi    <= iter_acc;
              lo    <= iter_wlo;
              state <= DONE;
            end
          end
        end
        FIX_LO: begin
          lo_zero <= (wlo == 32'd0);
          if (neg_q) wlo <= alu_out;
          state <= FIX_HI;
        end
        FIX_HI: begin
          acc   <= fix_acc;
          hi    <= fix_acc;
          lo    <= wlo;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
